// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary-to-BCD converter.
// One operand bit is consumed per clock, so a conversion takes BIN_W cycles.
// A start/busy/done handshake is used, and a new start is accepted in the
// same cycle that done is high. bcd, ovf and sign keep the last result until
// the next done.
// Optional build macro BIN2BCD_SIGN_EN: bin is read as two's complement. The
// magnitude is converted and the sign is reported on sign. Without the macro,
// bin is unsigned and sign stays 0. The port list is the same in both builds.
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic                  sign
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Each digit that is 5 or more gets +3 before the shift. The 4-bit add
    // does not carry into the next digit.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        r = d;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = d[4*i +: 4];
            end
        end
        return r;
    endfunction

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BIN_W-1:0]   shreg_q;
    logic [BCD_W-1:0]   digits_q;
    logic               sticky_q;
    logic               sign_lat_q;
    logic               busy_q;
    logic               done_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               ovf_q;
    logic               sign_q;

    logic [BCD_W-1:0]   digits_corr_s;
    logic [BCD_W-1:0]   digits_d;
    logic [BIN_W-1:0]   shreg_d;
    logic               carry_s;
    logic               sticky_d;
    logic [BIN_W-1:0]   mag_s;
    logic               sgn_s;

    // Operand conditioning: take the sign and the magnitude at acceptance.
    always_comb begin
`ifdef BIN2BCD_SIGN_EN
        sgn_s = bin[BIN_W-1];
        if (sgn_s) begin
            mag_s = ~bin + {{(BIN_W-1){1'b0}}, 1'b1};
        end else begin
            mag_s = bin;
        end
`else
        sgn_s = 1'b0;
        mag_s = bin;
`endif
    end

    // One double-dabble step: correct the digits, then shift {digits, shreg} left.
    // The bit that leaves the top digit means the value has reached 10^DIGITS.
    always_comb begin
        digits_corr_s = add3_digits(digits_q);
        {carry_s, digits_d, shreg_d} = {digits_corr_s, shreg_q, 1'b0};
        sticky_d = sticky_q | carry_s;
    end

    // Control FSM and datapath registers. All outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            digits_q   <= '0;
            sticky_q   <= 1'b0;
            sign_lat_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            sign_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shreg_q    <= mag_s;
                        digits_q   <= '0;
                        sticky_q   <= 1'b0;
                        sign_lat_q <= sgn_s;
                        cnt_q      <= CNT_W'(BIN_W);
                        busy_q     <= 1'b1;
                        state_q    <= ST_SHIFT;
                    end else begin
                        busy_q     <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    shreg_q  <= shreg_d;
                    digits_q <= digits_d;
                    sticky_q <= sticky_d;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        bcd_q   <= digits_d;
                        ovf_q   <= sticky_d;
                        sign_q  <= sign_lat_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;
    assign sign = sign_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq. It uses a 16-bit/5-digit instance and a
// 14-bit/4-digit instance. Expected results are hand-computed. They depend on
// whether BIN2BCD_SIGN_EN is defined.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start16, start14;
    logic [15:0] bin16;
    logic [13:0] bin14;
    logic        busy16, done16, ovf16, sign16;
    logic [19:0] bcd16;
    logic        busy14, done14, ovf14, sign14;
    logic [15:0] bcd14;

    int chk_cnt  = 0;
    int pass_cnt = 0;

`ifdef BIN2BCD_SIGN_EN
    localparam logic [19:0] EXP_FFFF     = 20'h00001;
    localparam logic        EXP_FFFF_SGN = 1'b1;
    localparam logic [15:0] EXP_9999     = 16'h6385;
    localparam logic        EXP_9999_OVF = 1'b0;
    localparam logic [15:0] EXP_10000    = 16'h6384;
    localparam logic        EXP_10000_OVF= 1'b0;
    localparam logic [15:0] EXP_12345    = 16'h4039;
    localparam logic        EXP_12345_OVF= 1'b0;
    localparam logic        EXP_14_SGN   = 1'b1;
    localparam logic [19:0] EXP_N1234    = 20'h01234;
    localparam logic [19:0] EXP_8000     = 20'h32768;
    localparam logic        EXP_NEG_SGN  = 1'b1;
`else
    localparam logic [19:0] EXP_FFFF     = 20'h65535;
    localparam logic        EXP_FFFF_SGN = 1'b0;
    localparam logic [15:0] EXP_9999     = 16'h9999;
    localparam logic        EXP_9999_OVF = 1'b0;
    localparam logic [15:0] EXP_10000    = 16'h0000;
    localparam logic        EXP_10000_OVF= 1'b1;
    localparam logic [15:0] EXP_12345    = 16'h2345;
    localparam logic        EXP_12345_OVF= 1'b1;
    localparam logic        EXP_14_SGN   = 1'b0;
    localparam logic [19:0] EXP_N1234    = 20'h64302;
    localparam logic [19:0] EXP_8000     = 20'h32768;
    localparam logic        EXP_NEG_SGN  = 1'b0;
`endif

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .bin(bin16),
        .busy(busy16), .done(done16), .bcd(bcd16), .ovf(ovf16), .sign(sign16)
    );

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) u_dut14 (
        .clk(clk), .rst_n(rst_n), .start(start14), .bin(bin14),
        .busy(busy14), .done(done14), .bcd(bcd14), .ovf(ovf14), .sign(sign14)
    );

    always #5 clk = ~clk;

    // Drive one conversion on the 16-bit instance and report what came back.
    task automatic conv16(input logic [15:0] b, output int lat, output logic busy_e0,
                          output logic [19:0] r_bcd, output logic r_ovf, output logic r_sign);
        @(negedge clk);
        start16 = 1'b1;
        bin16   = b;
        @(posedge clk); #1;
        busy_e0 = busy16;
        start16 = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done16) break;
        end
        r_bcd  = bcd16;
        r_ovf  = ovf16;
        r_sign = sign16;
    endtask

    // Drive one conversion on the 14-bit instance and report what came back.
    task automatic conv14(input logic [13:0] b, output int lat,
                          output logic [15:0] r_bcd, output logic r_ovf, output logic r_sign);
        @(negedge clk);
        start14 = 1'b1;
        bin14   = b;
        @(posedge clk); #1;
        start14 = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done14) break;
        end
        r_bcd  = bcd14;
        r_ovf  = ovf14;
        r_sign = sign14;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start16 = 1'b0; start14 = 1'b0; bin16 = 16'd0; bin14 = 14'd0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++; if (busy16 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy16); else pass_cnt++;
        chk_cnt++; if (done16 !== 1'b0) $display("FAIL reset_done got %b want 0", done16); else pass_cnt++;
        chk_cnt++; if (bcd16 !== 20'h00000) $display("FAIL reset_bcd got %h want 00000", bcd16); else pass_cnt++;
        chk_cnt++; if ({ovf16, sign16, busy14, done14, ovf14, sign14} !== 6'b000000)
            $display("FAIL reset_flags got %b want 000000", {ovf16, sign16, busy14, done14, ovf14, sign14}); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_wide16();
        int lat; logic be0; logic [19:0] r; logic o, s;
        conv16(16'd65535, lat, be0, r, o, s);
        chk_cnt++; if (be0 !== 1'b1) $display("FAIL busy_after_accept got %b want 1", be0); else pass_cnt++;
        chk_cnt++; if (lat !== 16) $display("FAIL latency16 got %0d want 16", lat); else pass_cnt++;
        chk_cnt++; if (r !== EXP_FFFF) $display("FAIL bcd_65535 got %h want %h", r, EXP_FFFF); else pass_cnt++;
        chk_cnt++; if ({o, s} !== {1'b0, EXP_FFFF_SGN}) $display("FAIL flags_65535 got %b want %b", {o, s}, {1'b0, EXP_FFFF_SGN}); else pass_cnt++;
        chk_cnt++; if (busy16 !== 1'b0) $display("FAIL busy_at_done got %b want 0", busy16); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if (done16 !== 1'b0) $display("FAIL done_width got %b want 0", done16); else pass_cnt++;
        chk_cnt++; if (bcd16 !== EXP_FFFF) $display("FAIL bcd_hold got %h want %h", bcd16, EXP_FFFF); else pass_cnt++;
        conv16(16'd0, lat, be0, r, o, s);
        chk_cnt++; if ({lat == 16, r, o, s} !== {1'b1, 20'h00000, 2'b00})
            $display("FAIL bcd_zero got lat=%0d bcd=%h ovf=%b sign=%b want lat=16 bcd=00000 ovf=0 sign=0", lat, r, o, s); else pass_cnt++;
    endtask

    task automatic test_overflow14();
        int lat; logic [15:0] r; logic o, s;
        conv14(14'd9999, lat, r, o, s);
        chk_cnt++; if (lat !== 14) $display("FAIL latency14 got %0d want 14", lat); else pass_cnt++;
        chk_cnt++; if ({r, o, s} !== {EXP_9999, EXP_9999_OVF, EXP_14_SGN})
            $display("FAIL conv_9999 got %h/%b/%b want %h/%b/%b", r, o, s, EXP_9999, EXP_9999_OVF, EXP_14_SGN); else pass_cnt++;
        conv14(14'd10000, lat, r, o, s);
        chk_cnt++; if ({r, o, s} !== {EXP_10000, EXP_10000_OVF, EXP_14_SGN})
            $display("FAIL conv_10000 got %h/%b/%b want %h/%b/%b", r, o, s, EXP_10000, EXP_10000_OVF, EXP_14_SGN); else pass_cnt++;
        conv14(14'd12345, lat, r, o, s);
        chk_cnt++; if ({r, o, s} !== {EXP_12345, EXP_12345_OVF, EXP_14_SGN})
            $display("FAIL conv_12345 got %h/%b/%b want %h/%b/%b", r, o, s, EXP_12345, EXP_12345_OVF, EXP_14_SGN); else pass_cnt++;
    endtask

    task automatic test_ignore_start();
        int ndone = 0; int first = 0; logic [19:0] r = 20'h0;
        @(negedge clk); start16 = 1'b1; bin16 = 16'd1234;
        @(posedge clk); #1; start16 = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 5) begin start16 = 1'b1; bin16 = 16'd9999; end
            if (cyc == 6) start16 = 1'b0;
            if (done16) begin
                ndone++;
                if (ndone == 1) begin first = cyc; r = bcd16; end
            end
        end
        chk_cnt++; if (ndone !== 1) $display("FAIL ignore_done_count got %0d want 1", ndone); else pass_cnt++;
        chk_cnt++; if (first !== 16) $display("FAIL ignore_latency got %0d want 16", first); else pass_cnt++;
        chk_cnt++; if (r !== 20'h01234) $display("FAIL ignore_bcd got %h want 01234", r); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int d1 = 0; int d2 = 0; logic b17 = 1'b0; logic dn17 = 1'b1;
        logic [19:0] r1 = 20'h0; logic [19:0] r2 = 20'h0; logic [19:0] r20 = 20'h0;
        @(negedge clk); start16 = 1'b1; bin16 = 16'd1111;
        @(posedge clk); #1; bin16 = 16'd2222;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 17) begin b17 = busy16; dn17 = done16; start16 = 1'b0; end
            if (cyc == 20) r20 = bcd16;
            if (done16 && d1 == 0) begin d1 = cyc; r1 = bcd16; end
            else if (done16 && d2 == 0) begin d2 = cyc; r2 = bcd16; end
        end
        start16 = 1'b0;
        chk_cnt++; if ({d1, r1} !== {32'sd16, 20'h01111}) $display("FAIL b2b_first got cyc=%0d bcd=%h want cyc=16 bcd=01111", d1, r1); else pass_cnt++;
        chk_cnt++; if ({b17, dn17} !== 2'b10) $display("FAIL b2b_no_idle got busy/done=%b%b want 10", b17, dn17); else pass_cnt++;
        chk_cnt++; if (r20 !== 20'h01111) $display("FAIL b2b_hold got %h want 01111", r20); else pass_cnt++;
        chk_cnt++; if ({d2, r2} !== {32'sd33, 20'h02222}) $display("FAIL b2b_second got cyc=%0d bcd=%h want cyc=33 bcd=02222", d2, r2); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int lat; int ndone = 0; logic be0; logic [19:0] r; logic o, s; logic bmid;
        @(negedge clk); start16 = 1'b1; bin16 = 16'd4321;
        @(posedge clk); #1; start16 = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        bmid = busy16;
        chk_cnt++; if (bmid !== 1'b1) $display("FAIL midrst_busy_before got %b want 1", bmid); else pass_cnt++;
        rst_n = 1'b0; #1;
        chk_cnt++; if ({busy16, done16, ovf16, sign16} !== 4'b0000)
            $display("FAIL midrst_flags got %b want 0000", {busy16, done16, ovf16, sign16}); else pass_cnt++;
        chk_cnt++; if (bcd16 !== 20'h00000) $display("FAIL midrst_bcd got %h want 00000", bcd16); else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            if (done16 || busy16) ndone++;
        end
        chk_cnt++; if (ndone !== 0) $display("FAIL midrst_no_done got %0d want 0", ndone); else pass_cnt++;
        conv16(16'd77, lat, be0, r, o, s);
        chk_cnt++; if ({lat == 16, r} !== {1'b1, 20'h00077}) $display("FAIL after_rst_77 got lat=%0d bcd=%h want lat=16 bcd=00077", lat, r); else pass_cnt++;
    endtask

    task automatic test_sign();
        int lat; logic be0; logic [19:0] r; logic o, s;
        conv16(16'hFB2E, lat, be0, r, o, s);
        chk_cnt++; if ({r, o, s} !== {EXP_N1234, 1'b0, EXP_NEG_SGN})
            $display("FAIL sign_m1234 got %h/%b/%b want %h/0/%b", r, o, s, EXP_N1234, EXP_NEG_SGN); else pass_cnt++;
        conv16(16'h8000, lat, be0, r, o, s);
        chk_cnt++; if ({r, o, s} !== {EXP_8000, 1'b0, EXP_NEG_SGN})
            $display("FAIL sign_m32768 got %h/%b/%b want %h/0/%b", r, o, s, EXP_8000, EXP_NEG_SGN); else pass_cnt++;
        conv16(16'd500, lat, be0, r, o, s);
        chk_cnt++; if ({r, o, s} !== {20'h00500, 2'b00})
            $display("FAIL sign_p500 got %h/%b/%b want 00500/0/0", r, o, s); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_wide16();
        test_overflow14();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        test_sign();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
